// File: rtl/alu_stage_pkg.sv
// rtl/alu_stage_pkg.sv - shared types and constants for the EX->MEM flag commit stage
package alu_stage_pkg;

  typedef enum logic [2:0] {
    CCC_NEQ    = 3'b000,
    CCC_EQ     = 3'b001,
    CCC_GT     = 3'b010,
    CCC_LT     = 3'b011,
    CCC_GTE    = 3'b100,
    CCC_LTE    = 3'b101,
    CCC_OVFL   = 3'b110,
    CCC_UNCOND = 3'b111
  } ccc_e;

  localparam int FLAG_N = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;

  localparam logic [2:0] FLAG_WR_ARITH = 3'b111;
  localparam logic [2:0] FLAG_WR_LOGIC = 3'b100;
  localparam logic [2:0] FLAG_WR_NONE  = 3'b000;

endpackage

// File: rtl/flag_commit_stage_if.sv
// rtl/flag_commit_stage_if.sv - valid/ready entry bus carrying an arithmetic result and its flags
interface flag_commit_stage_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_W-1:0]     result;
  logic                  v;
  logic                  n;
  logic                  z;
  logic [2:0]            flag_wr;
  logic                  is_branch;
  logic [2:0]            ccc;
  logic [REG_ADDR_W-1:0] dst;
  logic                  wb_en;
  logic                  br_taken;

  modport master (
    output valid, result, v, n, z, flag_wr, is_branch, ccc, dst, wb_en, br_taken,
    input  ready
  );

  modport slave (
    input  valid, result, v, n, z, flag_wr, is_branch, ccc, dst, wb_en,
    output ready
  );

endinterface

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational condition-code resolution against {Z,V,N}
module branch_cond_eval
  import alu_stage_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z, v, n;

  always_comb begin
    z     = flags[FLAG_Z];
    v     = flags[FLAG_V];
    n     = flags[FLAG_N];
    taken = 1'b0;
    case (ccc_e'(ccc))
      CCC_NEQ:    taken = ~z;
      CCC_EQ:     taken = z;
      CCC_GT:     taken = ~z & ~n;
      CCC_LT:     taken = n;
      CCC_GTE:    taken = ~n | z;
      CCC_LTE:    taken = n | z;
      CCC_OVFL:   taken = v;
      CCC_UNCOND: taken = 1'b1;
      default:    taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_commit_stage.sv
// rtl/flag_commit_stage.sv - EX->MEM register, architectural flag commit and branch resolution
// Optional flag forwarding from the pending entry into branch resolution: FLAG_BYPASS_EN.
module flag_commit_stage
  import alu_stage_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  flag_commit_stage_if.slave   in_if,
  flag_commit_stage_if.master  out_if,
  output logic [2:0]           flags_q
);

  logic                  out_valid;
  logic [DATA_W-1:0]     out_result;
  logic [REG_ADDR_W-1:0] out_dst;
  logic                  out_wb_en;
  logic                  out_br_taken;
  logic [2:0]            out_flags;
  logic [2:0]            out_flag_wr;
  logic                  out_is_branch;
  logic [2:0]            out_ccc;

  logic [2:0] eff;
  logic       interlock;
  logic       in_ready;
  logic       acc;
  logic       retire;
  logic       taken;

  always_comb begin
    eff       = flags_q;
    interlock = 1'b0;
`ifdef FLAG_BYPASS_EN
    for (int i = 0; i < 3; i++) begin
      if (out_valid && out_flag_wr[i]) eff[i] = out_flags[i];
    end
`else
    // Without forwarding a branch must see the setter's flags in flags_q.
    interlock = in_if.valid & in_if.is_branch & out_valid & (|out_flag_wr);
`endif
  end

  assign in_ready = (~out_valid | out_if.ready) & ~interlock;
  assign acc      = in_if.valid & in_ready & ~flush;
  assign retire   = out_valid & out_if.ready;

  branch_cond_eval u_branch_cond_eval (
    .ccc   (in_if.ccc),
    .flags (eff),
    .taken (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_dst       <= '0;
      out_wb_en     <= 1'b0;
      out_br_taken  <= 1'b0;
      out_flags     <= '0;
      out_flag_wr   <= FLAG_WR_NONE;
      out_is_branch <= 1'b0;
      out_ccc       <= '0;
      flags_q       <= '0;
    end else begin
      // A retiring entry is older than anything flush kills, so it still commits.
      if (retire) begin
        for (int i = 0; i < 3; i++) begin
          if (out_flag_wr[i]) flags_q[i] <= out_flags[i];
        end
      end
      if (acc) begin
        out_valid     <= 1'b1;
        out_result    <= in_if.result;
        out_dst       <= in_if.dst;
        out_wb_en     <= in_if.wb_en;
        out_br_taken  <= in_if.is_branch & taken;
        out_flags     <= {in_if.z, in_if.v, in_if.n};
        out_flag_wr   <= in_if.is_branch ? FLAG_WR_NONE : in_if.flag_wr;
        out_is_branch <= in_if.is_branch;
        out_ccc       <= in_if.ccc;
      end else if (retire || flush) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign in_if.ready      = in_ready;
  assign out_if.valid     = out_valid;
  assign out_if.result    = out_result;
  assign out_if.dst       = out_dst;
  assign out_if.wb_en     = out_wb_en;
  assign out_if.br_taken  = out_br_taken;
  assign out_if.z         = out_flags[FLAG_Z];
  assign out_if.v         = out_flags[FLAG_V];
  assign out_if.n         = out_flags[FLAG_N];
  assign out_if.flag_wr   = out_flag_wr;
  assign out_if.is_branch = out_is_branch;
  assign out_if.ccc       = out_ccc;

endmodule

// File: tb/tb_flag_commit_stage.sv
// tb/tb_flag_commit_stage.sv - directed self-checking bench for flag_commit_stage
module tb_flag_commit_stage;
  import alu_stage_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [2:0] flags_q;
  int         n_cmp;
  int         n_fail;

  flag_commit_stage_if #(.DATA_W(16), .REG_ADDR_W(4)) in_if ();
  flag_commit_stage_if #(.DATA_W(16), .REG_ADDR_W(4)) out_if ();

  flag_commit_stage #(.DATA_W(16), .REG_ADDR_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .in_if   (in_if),
    .out_if  (out_if),
    .flags_q (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_if.valid     = 1'b0;
    in_if.is_branch = 1'b0;
    in_if.flag_wr   = 3'b000;
  endtask

  task automatic drive(input logic [15:0] r, input logic v, input logic n, input logic z,
                       input logic [2:0] wr, input logic br, input logic [2:0] ccc,
                       input logic [3:0] dst, input logic wb);
    in_if.result    = r;
    in_if.v         = v;
    in_if.n         = n;
    in_if.z         = z;
    in_if.flag_wr   = wr;
    in_if.is_branch = br;
    in_if.ccc       = ccc;
    in_if.dst       = dst;
    in_if.wb_en     = wb;
    in_if.valid     = 1'b1;
  endtask

  // Present an entry, wait (bounded) for in_ready, take the accepting edge, go idle.
  task automatic send(input logic [15:0] r, input logic v, input logic n, input logic z,
                      input logic [2:0] wr, input logic br, input logic [2:0] ccc,
                      input logic [3:0] dst, input logic wb);
    drive(r, v, n, z, wr, br, ccc, dst, wb);
    #1;
    for (int i = 0; i < 8 && !in_if.ready; i++) tick;
    n_cmp++;
    if (in_if.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_accept: in_ready=%b required 1 within 8 cycles", in_if.ready);
    end
    tick;
    idle;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    n_cmp++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_if.valid); end
    n_cmp++; if (out_if.result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h want 0000", out_if.result); end
    n_cmp++; if (out_if.dst !== 4'h0) begin n_fail++; $display("FAIL reset_dst: got %h want 0", out_if.dst); end
    n_cmp++; if (out_if.wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en: got %b want 0", out_if.wb_en); end
    n_cmp++; if (out_if.br_taken !== 1'b0) begin n_fail++; $display("FAIL reset_br_taken: got %b want 0", out_if.br_taken); end
    n_cmp++; if (flags_q !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", flags_q); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_flag_commit;
    out_if.ready = 1'b1;
    send(16'h0000, 1'b0, 1'b0, 1'b1, FLAG_WR_ARITH, 1'b0, 3'b000, 4'h3, 1'b1);
    n_cmp++; if (out_if.valid !== 1'b1) begin n_fail++; $display("FAIL commit_valid: got %b want 1", out_if.valid); end
    n_cmp++; if (out_if.result !== 16'h0000) begin n_fail++; $display("FAIL commit_result: got %h want 0000", out_if.result); end
    n_cmp++; if (out_if.dst !== 4'h3) begin n_fail++; $display("FAIL commit_dst: got %h want 3", out_if.dst); end
    n_cmp++; if (out_if.wb_en !== 1'b1) begin n_fail++; $display("FAIL commit_wb_en: got %b want 1", out_if.wb_en); end
    n_cmp++; if (flags_q !== 3'b000) begin n_fail++; $display("FAIL commit_before_retire: got %b want 000", flags_q); end
    tick;
    n_cmp++; if (flags_q !== 3'b100) begin n_fail++; $display("FAIL commit_sub_z: got %b want 100", flags_q); end
    n_cmp++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL commit_drained: got %b want 0", out_if.valid); end
    // Logical op: V and N presented as 1 but masked out.
    send(16'h00F0, 1'b1, 1'b1, 1'b0, FLAG_WR_LOGIC, 1'b0, 3'b000, 4'h4, 1'b1);
    tick;
    n_cmp++; if (flags_q !== 3'b000) begin n_fail++; $display("FAIL commit_logic_mask: got %b want 000", flags_q); end
  endtask

  task automatic test_backpressure;
    out_if.ready = 1'b0;
    send(16'h1234, 1'b1, 1'b1, 1'b0, FLAG_WR_ARITH, 1'b0, 3'b000, 4'h5, 1'b1);
    drive(16'h5555, 1'b0, 1'b0, 1'b0, FLAG_WR_NONE, 1'b0, 3'b000, 4'h6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_if.ready); end
      n_cmp++; if (out_if.result !== 16'h1234) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h want 1234", i, out_if.result); end
      n_cmp++; if (flags_q !== 3'b000) begin n_fail++; $display("FAIL bp_flags[%0d]: got %b want 000", i, flags_q); end
      tick;
    end
    out_if.ready = 1'b1;
    #1;
    n_cmp++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_if.ready); end
    tick;
    idle;
    n_cmp++; if (flags_q !== 3'b011) begin n_fail++; $display("FAIL bp_commit: got %b want 011", flags_q); end
    n_cmp++; if (out_if.result !== 16'h5555) begin n_fail++; $display("FAIL bp_next_result: got %h want 5555", out_if.result); end
    n_cmp++; if (out_if.dst !== 4'h6) begin n_fail++; $display("FAIL bp_next_dst: got %h want 6", out_if.dst); end
    tick;
    n_cmp++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", out_if.valid); end
    n_cmp++; if (flags_q !== 3'b011) begin n_fail++; $display("FAIL bp_nowr_hold: got %b want 011", flags_q); end
  endtask

  task automatic test_branch_hazard;
    out_if.ready = 1'b1;
    send(16'h0001, 1'b0, 1'b0, 1'b0, FLAG_WR_ARITH, 1'b0, 3'b000, 4'h1, 1'b1);
    tick;
    n_cmp++; if (flags_q !== 3'b000) begin n_fail++; $display("FAIL hz_setup_flags: got %b want 000", flags_q); end
    out_if.ready = 1'b0;
    send(16'h8000, 1'b0, 1'b1, 1'b0, FLAG_WR_ARITH, 1'b0, 3'b000, 4'h2, 1'b1);
    // Branch carries a bogus mask and Z=1 that must be ignored.
    drive(16'h0000, 1'b0, 1'b0, 1'b1, FLAG_WR_ARITH, 1'b1, CCC_LT, 4'h0, 1'b0);
    #1;
    n_cmp++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL hz_held_ready: got %b want 0", in_if.ready); end
    tick;
    out_if.ready = 1'b1;
    #1;
`ifdef FLAG_BYPASS_EN
    n_cmp++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL hz_bypass_ready: got %b want 1", in_if.ready); end
    tick;
    idle;
    n_cmp++; if (out_if.valid !== 1'b1) begin n_fail++; $display("FAIL hz_bypass_valid: got %b want 1", out_if.valid); end
    n_cmp++; if (out_if.br_taken !== 1'b1) begin n_fail++; $display("FAIL hz_bypass_taken: got %b want 1", out_if.br_taken); end
    n_cmp++; if (flags_q !== 3'b001) begin n_fail++; $display("FAIL hz_add_commit: got %b want 001", flags_q); end
`else
    n_cmp++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL hz_interlock_ready: got %b want 0", in_if.ready); end
    tick;
    n_cmp++; if (flags_q !== 3'b001) begin n_fail++; $display("FAIL hz_add_commit: got %b want 001", flags_q); end
    n_cmp++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL hz_release_ready: got %b want 1", in_if.ready); end
    tick;
    idle;
    n_cmp++; if (out_if.valid !== 1'b1) begin n_fail++; $display("FAIL hz_branch_valid: got %b want 1", out_if.valid); end
    n_cmp++; if (out_if.br_taken !== 1'b1) begin n_fail++; $display("FAIL hz_branch_taken: got %b want 1", out_if.br_taken); end
`endif
    tick;
    n_cmp++; if (flags_q !== 3'b001) begin n_fail++; $display("FAIL hz_branch_nowr: got %b want 001", flags_q); end
    n_cmp++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL hz_drain: got %b want 0", out_if.valid); end
  endtask

  task automatic test_flush;
    out_if.ready = 1'b0;
    send(16'h1111, 1'b0, 1'b0, 1'b1, FLAG_WR_ARITH, 1'b0, 3'b000, 4'h7, 1'b1);
    drive(16'h2222, 1'b0, 1'b1, 1'b0, FLAG_WR_ARITH, 1'b0, 3'b000, 4'h8, 1'b1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    idle;
    n_cmp++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill_valid: got %b want 0", out_if.valid); end
    n_cmp++; if (flags_q !== 3'b001) begin n_fail++; $display("FAIL flush_kill_flags: got %b want 001", flags_q); end
    out_if.ready = 1'b1;
    tick;
    n_cmp++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_input: got %b want 0", out_if.valid); end
    n_cmp++; if (flags_q !== 3'b001) begin n_fail++; $display("FAIL flush_drop_flags: got %b want 001", flags_q); end
    send(16'h3333, 1'b1, 1'b0, 1'b1, FLAG_WR_ARITH, 1'b0, 3'b000, 4'h9, 1'b1);
    drive(16'h4444, 1'b0, 1'b1, 1'b0, FLAG_WR_ARITH, 1'b0, 3'b000, 4'hA, 1'b1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    idle;
    n_cmp++; if (flags_q !== 3'b110) begin n_fail++; $display("FAIL flush_retire_commit: got %b want 110", flags_q); end
    n_cmp++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL flush_retire_valid: got %b want 0", out_if.valid); end
    tick;
    n_cmp++; if (flags_q !== 3'b110) begin n_fail++; $display("FAIL flush_retire_dropped: got %b want 110", flags_q); end
  endtask

  task automatic test_saturation;
    out_if.ready = 1'b1;
    send(16'h7FFF, 1'b1, 1'b0, 1'b0, FLAG_WR_ARITH, 1'b0, 3'b000, 4'h1, 1'b1);
    n_cmp++; if (out_if.result !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos_result: got %h want 7fff", out_if.result); end
    send(16'h0000, 1'b0, 1'b0, 1'b0, FLAG_WR_NONE, 1'b1, CCC_OVFL, 4'h0, 1'b0);
    n_cmp++; if (out_if.br_taken !== 1'b1) begin n_fail++; $display("FAIL sat_ovfl_taken: got %b want 1", out_if.br_taken); end
    send(16'h8000, 1'b1, 1'b1, 1'b0, FLAG_WR_ARITH, 1'b0, 3'b000, 4'h2, 1'b1);
    n_cmp++; if (out_if.result !== 16'h8000) begin n_fail++; $display("FAIL sat_neg_result: got %h want 8000", out_if.result); end
    n_cmp++; if (out_if.br_taken !== 1'b0) begin n_fail++; $display("FAIL sat_nonbranch_taken: got %b want 0", out_if.br_taken); end
    send(16'h0000, 1'b0, 1'b0, 1'b0, FLAG_WR_NONE, 1'b1, CCC_LTE, 4'h0, 1'b0);
    n_cmp++; if (out_if.br_taken !== 1'b1) begin n_fail++; $display("FAIL sat_lte_taken: got %b want 1", out_if.br_taken); end
    send(16'h0000, 1'b0, 1'b0, 1'b0, FLAG_WR_NONE, 1'b1, CCC_GT, 4'h0, 1'b0);
    n_cmp++; if (out_if.br_taken !== 1'b0) begin n_fail++; $display("FAIL sat_gt_taken: got %b want 0", out_if.br_taken); end
    tick;
    n_cmp++; if (flags_q !== 3'b011) begin n_fail++; $display("FAIL sat_flags: got %b want 011", flags_q); end
  endtask

  task automatic test_async_reset;
    out_if.ready = 1'b1;
    send(16'h5A5A, 1'b1, 1'b1, 1'b1, FLAG_WR_ARITH, 1'b0, 3'b000, 4'hB, 1'b1);
    tick;
    n_cmp++; if (flags_q !== 3'b111) begin n_fail++; $display("FAIL areset_setup: got %b want 111", flags_q); end
    out_if.ready = 1'b0;
    send(16'h0BAD, 1'b0, 1'b0, 1'b0, FLAG_WR_ARITH, 1'b0, 3'b000, 4'hC, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", out_if.valid); end
    n_cmp++; if (flags_q !== 3'b000) begin n_fail++; $display("FAIL areset_flags: got %b want 000", flags_q); end
    n_cmp++; if (out_if.result !== 16'h0000) begin n_fail++; $display("FAIL areset_result: got %h want 0000", out_if.result); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    n_cmp              = 0;
    n_fail             = 0;
    rst_n              = 1'b0;
    flush              = 1'b0;
    out_if.ready       = 1'b1;
    in_if.br_taken     = 1'b0;
    in_if.result       = '0;
    in_if.v            = 1'b0;
    in_if.n            = 1'b0;
    in_if.z            = 1'b0;
    in_if.ccc          = 3'b000;
    in_if.dst          = '0;
    in_if.wb_en        = 1'b0;
    idle;
    test_reset;
    test_flag_commit;
    test_backpressure;
    test_branch_hazard;
    test_flush;
    test_saturation;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
